// File: rtl/srpl_rcv.sv
// Serial-to-parallel word receiver: sync-aligned shift register feeding a 16-deep FIFO with sticky overrun.
// Build option SRPL_RCV_MSB_FIRST_EN selects MSB-first assembly; default is LSB-first.
module srpl_rcv #(
   parameter int w = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sdi,
   input  logic         en,
   input  logic         sync,
   input  logic         rd,
   input  logic         clr_ovr,
   output logic [w-1:0] q,
   output logic         empty,
   output logic         full,
   output logic [4:0]   level,
   output logic         ovr
);

   localparam int BW = $clog2(w);
   localparam logic [BW-1:0] BC_LAST = BW'(w - 1);

   logic [w-1:0]  r_q, r_d;
   logic [BW-1:0] bc_q, bc_d;
   logic [3:0]    wp_q, wp_d;
   logic [3:0]    rp_q, rp_d;
   logic [4:0]    level_q, level_d;
   logic          ovr_q, ovr_d;
   logic [w-1:0]  ram_q [16];

   logic pop;
   logic cmpl;
   logic wr_ok;

   always_comb begin
      r_d = r_q;
      if (en) begin
`ifdef SRPL_RCV_MSB_FIRST_EN
         r_d = {r_q[w-2:0], sdi};
`else
         r_d = {sdi, r_q[w-1:1]};
`endif
      end

      pop   = rd & ~empty;
      cmpl  = en & ~sync & (bc_q == BC_LAST);
      // A pop in the same cycle frees the slot the completing word needs.
      wr_ok = cmpl & (~full | pop);

      bc_d = bc_q;
      if (en) begin
         if (sync)
            bc_d = BW'(1);
         else if (bc_q == BC_LAST)
            bc_d = '0;
         else
            bc_d = bc_q + BW'(1);
      end

      wp_d = wr_ok ? wp_q + 4'd1 : wp_q;
      rp_d = pop ? rp_q + 4'd1 : rp_q;

      case ({wr_ok, pop})
         2'b10:   level_d = level_q + 5'd1;
         2'b01:   level_d = level_q - 5'd1;
         default: level_d = level_q;
      endcase

      if (cmpl & ~wr_ok)
         ovr_d = 1'b1;
      else if (clr_ovr)
         ovr_d = 1'b0;
      else
         ovr_d = ovr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         bc_q    <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         r_q     <= r_d;
         bc_q    <= bc_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
         ovr_q   <= ovr_d;
      end
   end

   // Storage is never cleared; reset only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok)
         ram_q[wp_q] <= r_d;
   end

   assign q     = ram_q[rp_q];
   assign empty = (level_q == 5'd0);
   assign full  = (level_q == 5'd16);
   assign level = level_q;
   assign ovr   = ovr_q;

endmodule

// File: doc/srpl_rcv.md
# srpl_rcv

Serial-to-parallel word receiver, the receive end of the parallel-load serializer link (LSB-first, one bit per enabled clock). It assembles `w`-bit words from a strobed serial stream, realigns on a frame-sync marker, and queues completed words in a 16-deep distributed-RAM FIFO with a pop handshake toward the consuming logic. Overflow is flagged sticky, never silently absorbed.

## Interface
- `w`, 16: word width, 2..32.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `sdi`  in  1: serial data in.
- `en`  in  1: bit strobe; `sdi` sampled only when `en`=1.
- `sync`  in  1: frame marker, qualified by `en`; the bit sampled with `en&sync` is bit 0 of a new word.
- `rd`  in  1: pop request; ignored when `empty`.
- `clr_ovr`  in  1: clears `ovr`.
- `q`  out  w: FIFO head word, combinational from RAM at read pointer; valid when `empty`=0.
- `empty`  out  1: FIFO empty.
- `full`  out  1: FIFO holds 16 words.
- `level`  out  5: words stored, 0..16.
- `ovr`  out  1: sticky overrun, a completed word was dropped.

## Operation
- Shift register `r[w-1:0]`, bit counter `bc` (0..w-1), write pointer `wp[3:0]`, read pointer `rp[3:0]`, `level[4:0]`, `ovr`.
- On `en`: `r <= {sdi, r[w-1:1]}` (first received bit ends in `r[0]`).
- `en&sync`: `bc <= 1`; partial word discarded; sampled bit becomes bit 0 (single-bit word completes when `w`... not allowed, `w`>=2).
- `en&!sync`: `bc <= (bc==w-1) ? 0 : bc+1`.
- Word completion: `en & !sync & bc==w-1`; completed word `{sdi, r[w-1:1]}` written to `ram[wp]` the same edge, `wp <= wp+1`.
- Write accepted iff `!full || pop`, where `pop = rd & !empty`. Otherwise word dropped, `ovr <= 1`, `wp` unchanged.
- Pop: `rp <= rp+1`. `rd` with `empty`=1: no effect.
- `level`: +1 on accepted write only, -1 on pop only, unchanged on both or neither.
- `empty = (level==0)`, `full = (level==16)`, decoded from `level`.
- `ovr`: set by dropped word; cleared by `clr_ovr`; set wins when both in one cycle.
- Pointers wrap 15->0 naturally (4-bit).
- `rst`: `r`=0, `bc`=0, `wp`=`rp`=0, `level`=0, `ovr`=0; RAM contents not cleared. Reset mid-word discards partial word; reset overrides all other inputs that cycle.

## Timing
- Reset values: `empty`=1, `full`=0, `level`=0, `ovr`=0, `q`=don't-care (RAM content).
- Latency: last bit sampled at edge N -> `empty`=0 and `q` valid after edge N (usable in cycle N+1).
- Pop at edge M -> next word on `q` after edge M; back-to-back pops at one per clock.
- Full + completion + `rd` in same cycle: write accepted, `level` stays 16, no `ovr`.
- `en` may be held high continuously (one bit per clock); no minimum gap.
- `sync` without `en` ignored.

## Configuration
- `SRPL_RCV_MSB_FIRST_EN`: defined -> shift is `r <= {r[w-2:0], sdi}`, first received bit becomes word MSB, completed word `{r[w-2:0], sdi}`; undefined -> LSB-first as above (matches the serializer). Framing, FIFO and flags identical in both builds.

## Test plan
- `w`=16, sync on first bit, continuous `en`, stream 0xA5C3 LSB-first -> after 16th bit edge `empty`=0, `q`=0xA5C3, `level`=1; `rd` pulse -> `empty`=1.
- 5 random bits, then `sync` with stream 0x1234 -> only 0x1234 queued, `level`=1, `ovr`=0.
- 17 words 0x0000..0x0010 with no `rd` -> `full`=1 after 16th, 17th dropped, `ovr`=1; pops return 0x0000..0x000F, `ovr` stays 1 until `clr_ovr`.
- FIFO full, 17th word completes in same cycle as `rd` -> `level`=16, `ovr`=0, final pop order ends with 17th word.
- `rst` asserted after 8 bits of a word -> all outputs at reset values; subsequent sync'd word 0xBEEF received intact.
- `SRPL_RCV_MSB_FIRST_EN` build: bits 1,0,0,0...0 (16) -> `q`=0x8000; default build same bits -> `q`=0x0001.
